// File: rtl/csi2_packet_parser.sv
// CSI-2 packet parser for a single-lane HS-only D-PHY byte stream: header, payload, footer, then phy_reset flush.
// Optional header ECC checking is compiled in with `define CSI2_ECC_CHECK_EN.
module csi2_packet_parser #(
  parameter logic [5:0]  LONG_DT_MIN  = 6'h10,
  parameter int unsigned FOOTER_BYTES = 2,
  parameter int unsigned RESET_HOLD   = 2
) (
  input  logic        clock_p,
  input  logic        reset_n,
  input  logic [7:0]  data,
  input  logic        enable,
  output logic        phy_reset,
  output logic        packet_start,
  output logic [1:0]  virtual_channel,
  output logic [5:0]  data_type,
  output logic [15:0] word_count,
  output logic        short_packet,
  output logic [7:0]  payload,
  output logic        payload_valid,
  output logic        payload_last,
  output logic        header_error
);

  typedef enum logic [1:0] {
    S_HDR,
    S_PAYLOAD,
    S_FOOTER,
    S_FLUSH
  } state_t;

  // A build without footer bytes goes straight from the payload to the flush.
  localparam state_t     AFTER_PAYLOAD = (FOOTER_BYTES == 0) ? S_FLUSH : S_FOOTER;
  localparam logic [7:0] FTR_LAST      = 8'(FOOTER_BYTES - 1);
  localparam logic [3:0] HOLD_LAST     = 4'(RESET_HOLD - 1);

  state_t      state_q, state_d;
  logic [1:0]  hdr_idx_q;
  logic [7:0]  di_q, wc_lsb_q, wc_msb_q;
  logic [15:0] pay_cnt_q;
  logic [7:0]  ftr_cnt_q;
  logic [3:0]  flush_cnt_q;

  logic [15:0] hdr_wc;
  logic        hdr_short;
  logic        hdr_last;
  logic        ecc_ok;
  logic        hdr_ok;
  logic        pay_fire;
  logic        pay_end;

  assign hdr_wc    = {wc_msb_q, wc_lsb_q};
  assign hdr_short = (di_q[5:0] < LONG_DT_MIN);
  // The ECC byte is live on data while DI and WC already sit in their registers.
  assign hdr_last  = (state_q == S_HDR) && enable && (hdr_idx_q == 2'd3);

`ifdef CSI2_ECC_CHECK_EN
  // Each parity bit is the XOR of the header bits selected by its row mask.
  function automatic logic [5:0] csi2_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  logic hdr_bad;

  assign ecc_ok  = (data[7:6] == 2'b00) &&
                   (csi2_ecc({wc_msb_q, wc_lsb_q, di_q}) == data[5:0]);
  assign hdr_bad = hdr_last && !ecc_ok;
`else
  assign ecc_ok       = 1'b1;
  assign header_error = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    hdr_ok   = 1'b0;
    pay_fire = 1'b0;
    pay_end  = 1'b0;
    unique case (state_q)
      S_HDR: begin
        if (hdr_last) begin
          if (!ecc_ok) begin
            state_d = S_FLUSH;
          end else begin
            hdr_ok = 1'b1;
            if (hdr_short)              state_d = S_FLUSH;
            else if (hdr_wc == 16'd0)   state_d = AFTER_PAYLOAD;
            else                        state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (enable) begin
          pay_fire = 1'b1;
          if (pay_cnt_q == 16'd1) begin
            pay_end = 1'b1;
            state_d = AFTER_PAYLOAD;
          end
        end
      end
      S_FOOTER: begin
        if (enable && (ftr_cnt_q == FTR_LAST)) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // enable is deliberately not looked at here, including on the final hold cycle.
        if (flush_cnt_q == HOLD_LAST) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on clock_p.
  always_ff @(posedge clock_p) begin
    if (!reset_n) begin
      state_q         <= S_HDR;
      hdr_idx_q       <= '0;
      di_q            <= '0;
      wc_lsb_q        <= '0;
      wc_msb_q        <= '0;
      pay_cnt_q       <= '0;
      ftr_cnt_q       <= '0;
      flush_cnt_q     <= '0;
      phy_reset       <= 1'b0;
      packet_start    <= 1'b0;
      virtual_channel <= '0;
      data_type       <= '0;
      word_count      <= '0;
      short_packet    <= 1'b0;
      payload         <= '0;
      payload_valid   <= 1'b0;
      payload_last    <= 1'b0;
`ifdef CSI2_ECC_CHECK_EN
      header_error    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      // Registered from the next state so phy_reset is high exactly while in FLUSH.
      phy_reset     <= (state_d == S_FLUSH);
      packet_start  <= hdr_ok;
      payload_valid <= pay_fire;
      payload_last  <= pay_end;
`ifdef CSI2_ECC_CHECK_EN
      header_error  <= hdr_bad;
`endif

      if (pay_fire) payload <= data;

      if (state_q != S_HDR) begin
        hdr_idx_q <= '0;
      end else if (enable) begin
        hdr_idx_q <= hdr_idx_q + 2'd1;
        case (hdr_idx_q)
          2'd0:    di_q     <= data;
          2'd1:    wc_lsb_q <= data;
          2'd2:    wc_msb_q <= data;
          default: ;
        endcase
      end

      // Fields only move on an accepted header, so they survive FLUSH and ECC failures.
      if (hdr_ok) begin
        virtual_channel <= di_q[7:6];
        data_type       <= di_q[5:0];
        word_count      <= hdr_wc;
        short_packet    <= hdr_short;
        pay_cnt_q       <= hdr_wc;
      end else if (pay_fire) begin
        pay_cnt_q <= pay_cnt_q - 16'd1;
      end

      if (state_q != S_FOOTER) ftr_cnt_q <= '0;
      else if (enable)         ftr_cnt_q <= ftr_cnt_q + 8'd1;

      if (state_q != S_FLUSH)  flush_cnt_q <= '0;
      else                     flush_cnt_q <= flush_cnt_q + 4'd1;
    end
  end

endmodule

// File: tb/tb_csi2_packet_parser.sv
// Self-checking bench for csi2_packet_parser: directed timing, a packet table and randomized packets
// scored against a packet-level model; the ECC error case runs when CSI2_ECC_CHECK_EN is defined.
module tb_csi2_packet_parser;

  localparam int RESET_HOLD = 2;

  // Syndrome contribution of each header bit D0..D23 to the 6-bit CSI-2 ECC.
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
  };

  logic        clock_p = 1'b0;
  logic        reset_n;
  logic [7:0]  data;
  logic        enable;
  logic        phy_reset, packet_start, short_packet;
  logic [1:0]  virtual_channel;
  logic [5:0]  data_type;
  logic [15:0] word_count;
  logic [7:0]  payload;
  logic        payload_valid, payload_last, header_error;

  csi2_packet_parser dut (
    .clock_p        (clock_p),
    .reset_n        (reset_n),
    .data           (data),
    .enable         (enable),
    .phy_reset      (phy_reset),
    .packet_start   (packet_start),
    .virtual_channel(virtual_channel),
    .data_type      (data_type),
    .word_count     (word_count),
    .short_packet   (short_packet),
    .payload        (payload),
    .payload_valid  (payload_valid),
    .payload_last   (payload_last),
    .header_error   (header_error)
  );

  always #5 clock_p = ~clock_p;

  typedef struct packed {
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic        sp;
  } hdr_t;

  typedef struct packed {
    logic       is_last;
    logic [7:0] b;
  } pay_t;

  typedef struct {
    string       name;
    logic [7:0]  di;
    logic [15:0] wc;
    int          spacing;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic        sp;
    int          npay;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  hdr_t obs_hdr[$];
  pay_t obs_pay[$];
  int   obs_runs[$];
  int   herr_cnt = 0;
  int   run_len  = 0;
  hdr_t last_hdr = '0;

  // Observer: samples outputs on the falling edge, halfway between active edges.
  always @(negedge clock_p) begin
    if (packet_start)
      obs_hdr.push_back(hdr_t'{vc: virtual_channel, dt: data_type, wc: word_count, sp: short_packet});
    if (payload_valid)
      obs_pay.push_back(pay_t'{is_last: payload_last, b: payload});
    if (header_error) herr_cnt++;
    if (phy_reset) run_len++;
    else if (run_len != 0) begin
      obs_runs.push_back(run_len);
      run_len = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] ecc_model(input logic [23:0] d);
    logic [5:0] e = '0;
    for (int i = 0; i < 24; i++) if (d[i]) e ^= ECC_COL[i];
    return e;
  endfunction

  function automatic hdr_t model_hdr(input logic [7:0] di, input logic [15:0] wc);
    hdr_t h;
    h.vc = 2'(di / 64);
    h.dt = 6'(di % 64);
    h.wc = wc;
    h.sp = (int'(di % 64) < 16);
    return h;
  endfunction

  function automatic int model_npay(input hdr_t h);
    return h.sp ? 0 : int'(h.wc);
  endfunction

  task automatic clear_obs();
    obs_hdr.delete();
    obs_pay.delete();
    obs_runs.delete();
  endtask

  // Presents one byte for one cycle, then idles so the next byte starts `spacing` cycles later.
  task automatic send(input logic [7:0] b, input int spacing);
    data   = b;
    enable = 1'b1;
    @(negedge clock_p);
    enable = 1'b0;
    data   = 8'($urandom);
    repeat (spacing - 1) @(negedge clock_p);
  endtask

  // Feeds junk with enable high until phy_reset has risen and fallen again.
  task automatic flush_wait(output bit ok, output bit prompt);
    bit seen = 1'b0;
    ok     = 1'b0;
    prompt = phy_reset;
    for (int k = 0; k < 64; k++) begin
      if (phy_reset) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
      data   = 8'($urandom);
      enable = 1'b1;
      @(negedge clock_p);
    end
    enable = 1'b0;
    if (!ok) begin
      reset_n = 1'b0;
      @(negedge clock_p);
      reset_n = 1'b1;
    end
  endtask

  task automatic run_packet(input string tag, input logic [7:0] di, input logic [15:0] wc,
                            input int spacing, input bit corrupt, input bit pat,
                            input hdr_t exp_h, input int exp_npay);
    logic [7:0] sent[$];
    logic [7:0] b;
    logic [7:0] ecc;
    int         herr0;
    int         nbad;
    int         nlast;
    int         last_pos;
    bit         ok;
    bit         prompt;
    bit         long_pkt;

    herr0    = herr_cnt;
    long_pkt = !corrupt && !exp_h.sp;
    ecc      = {2'b00, ecc_model({wc, di})};
    if (corrupt) ecc ^= 8'h04;

    send(di, spacing);
    send(wc[7:0], spacing);
    send(wc[15:8], spacing);
    send(ecc, long_pkt ? spacing : 1);
    if (long_pkt) begin
      for (int i = 0; i < exp_npay; i++) begin
        b = pat ? 8'(8'h11 * (i + 1)) : 8'($urandom);
        sent.push_back(b);
        send(b, spacing);
      end
      send(8'hAB, spacing);
      send(8'hCD, 1);
    end

    flush_wait(ok, prompt);
    #1;
    check({tag, ":flush_done"}, 32'(ok), 1);
    check({tag, ":phy_prompt"}, 32'(prompt), 1);
    check({tag, ":phy_runs"}, obs_runs.size(), 1);
    if (obs_runs.size() > 0) check({tag, ":phy_len"}, obs_runs[0], RESET_HOLD);

    if (corrupt) begin
      check({tag, ":no_start"}, obs_hdr.size(), 0);
      check({tag, ":herr_pulses"}, herr_cnt - herr0, 1);
      check({tag, ":fields_kept"}, {virtual_channel, data_type, word_count, short_packet}, last_hdr);
    end else begin
      check({tag, ":starts"}, obs_hdr.size(), 1);
      if (obs_hdr.size() > 0) check({tag, ":fields"}, obs_hdr[0], exp_h);
      check({tag, ":fields_held"}, {virtual_channel, data_type, word_count, short_packet}, exp_h);
      last_hdr = exp_h;
    end

    check({tag, ":pay_count"}, obs_pay.size(), sent.size());
    nbad = 0;
    nlast = 0;
    last_pos = -1;
    for (int i = 0; i < obs_pay.size(); i++) begin
      if (i < sent.size() && obs_pay[i].b !== sent[i]) nbad++;
      if (obs_pay[i].is_last) begin
        nlast++;
        last_pos = i;
      end
    end
    check({tag, ":pay_bytes"}, nbad, 0);
    check({tag, ":last_count"}, nlast, (sent.size() > 0) ? 1 : 0);
    if (sent.size() > 0) check({tag, ":last_pos"}, last_pos, sent.size() - 1);
    clear_obs();
  endtask

  initial begin
    vec_t        vecs[9];
    int          spc[3] = '{1, 2, 4};
    logic [7:0]  ecc;
    logic [7:0]  b;
    logic [7:0]  di;
    logic [15:0] wc;
    hdr_t        h;
    int          nlast;

    vecs[0] = '{"short",    8'h00, 16'h0001, 4, 2'd0, 6'h00, 1'b1, 0};
    vecs[1] = '{"long",     8'h2A, 16'h0004, 4, 2'd0, 6'h2A, 1'b0, 4};
    vecs[2] = '{"zero_len", 8'h2B, 16'h0000, 4, 2'd0, 6'h2B, 1'b0, 0};
    vecs[3] = '{"b2b_a",    8'h2A, 16'h0004, 1, 2'd0, 6'h2A, 1'b0, 4};
    vecs[4] = '{"b2b_b",    8'h6C, 16'h0007, 1, 2'd1, 6'h2C, 1'b0, 7};
    vecs[5] = '{"dt_0f",    8'h0F, 16'h1234, 1, 2'd0, 6'h0F, 1'b1, 0};
    vecs[6] = '{"dt_10",    8'h10, 16'h0003, 2, 2'd0, 6'h10, 1'b0, 3};
    vecs[7] = '{"vc3",      8'hFF, 16'h0002, 1, 2'd3, 6'h3F, 1'b0, 2};
    vecs[8] = '{"wc_256",   8'h92, 16'h0100, 1, 2'd2, 6'h12, 1'b0, 256};

    reset_n = 1'b0;
    enable  = 1'b0;
    data    = 8'h00;
    repeat (3) @(negedge clock_p);
    check("reset:fields", {virtual_channel, data_type, word_count, short_packet}, 0);
    check("reset:strobes", {phy_reset, packet_start, payload, payload_valid, payload_last, header_error}, 0);
    reset_n = 1'b1;
    @(negedge clock_p);

    // Cycle-exact long packet: 2A / WC=4 / 11 22 33 44 / AB CD, one enable every 4 cycles.
    ecc = {2'b00, ecc_model({16'h0004, 8'h2A})};
    send(8'h2A, 4);
    send(8'h04, 4);
    send(8'h00, 4);
    data = ecc; enable = 1'b1;
    @(negedge clock_p);
    enable = 1'b0;
    check("t:packet_start", packet_start, 1);
    check("t:fields", {virtual_channel, data_type, word_count, short_packet}, {2'd0, 6'h2A, 16'h0004, 1'b0});
    @(negedge clock_p);
    check("t:start_pulse", packet_start, 0);
    repeat (2) @(negedge clock_p);
    for (int i = 0; i < 4; i++) begin
      b = 8'(8'h11 * (i + 1));
      data = b; enable = 1'b1;
      @(negedge clock_p);
      enable = 1'b0;
      check("t:pay_valid", payload_valid, 1);
      check("t:pay_data", payload, b);
      check("t:pay_last", payload_last, (i == 3) ? 1 : 0);
      @(negedge clock_p);
      check("t:valid_pulse", payload_valid, 0);
      repeat (2) @(negedge clock_p);
    end
    data = 8'hAB; enable = 1'b1;
    @(negedge clock_p);
    enable = 1'b0;
    check("t:footer_quiet", {phy_reset, payload_valid}, 0);
    repeat (3) @(negedge clock_p);
    data = 8'hCD; enable = 1'b1;
    @(negedge clock_p);
    enable = 1'b0;
    check("t:phy_rise", phy_reset, 1);
    @(negedge clock_p);
    check("t:phy_hold", phy_reset, 1);
    @(negedge clock_p);
    check("t:phy_fall", phy_reset, 0);
    #1;
    check("t:pay_total", obs_pay.size(), 4);
    last_hdr = hdr_t'{vc: 2'd0, dt: 6'h2A, wc: 16'h0004, sp: 1'b0};
    clear_obs();

    foreach (vecs[i])
      run_packet(vecs[i].name, vecs[i].di, vecs[i].wc, vecs[i].spacing, 1'b0, 1'b1,
                 hdr_t'{vc: vecs[i].vc, dt: vecs[i].dt, wc: vecs[i].wc, sp: vecs[i].sp},
                 vecs[i].npay);

    // Reset five bytes into a 16-byte payload.
    ecc = {2'b00, ecc_model({16'h0010, 8'h2A})};
    send(8'h2A, 4);
    send(8'h10, 4);
    send(8'h00, 4);
    send(ecc, 4);
    for (int i = 0; i < 5; i++) send(8'(8'h30 + i), (i == 4) ? 1 : 4);
    reset_n = 1'b0;
    @(negedge clock_p);
    #1;
    check("mid_rst:fields", {virtual_channel, data_type, word_count, short_packet}, 0);
    check("mid_rst:strobes", {phy_reset, packet_start, payload, payload_valid, payload_last, header_error}, 0);
    check("mid_rst:pay_seen", obs_pay.size(), 5);
    nlast = 0;
    foreach (obs_pay[i]) if (obs_pay[i].is_last) nlast++;
    check("mid_rst:no_last", nlast, 0);
    reset_n = 1'b1;
    last_hdr = '0;
    clear_obs();
    @(negedge clock_p);
    run_packet("after_rst", 8'hEA, 16'h0002, 4, 1'b0, 1'b1,
               hdr_t'{vc: 2'd3, dt: 6'h2A, wc: 16'h0002, sp: 1'b0}, 2);

`ifdef CSI2_ECC_CHECK_EN
    run_packet("ecc_err", 8'h2A, 16'h0004, 4, 1'b1, 1'b1,
               hdr_t'{vc: 2'd0, dt: 6'h2A, wc: 16'h0004, sp: 1'b0}, 0);
`endif

    for (int r = 0; r < 30; r++) begin
      di = 8'($urandom);
      wc = (int'(di % 64) < 16) ? 16'($urandom) : 16'($urandom_range(0, 24));
      h  = model_hdr(di, wc);
      run_packet($sformatf("rand%0d", r), di, wc, spc[$urandom_range(0, 2)], 1'b0, 1'b0,
                 h, model_npay(h));
    end

`ifdef CSI2_ECC_CHECK_EN
    check("header_error_total", herr_cnt, 1);
`else
    check("header_error_total", herr_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
